// File: rtl/nibble_add_sequencer_if.sv
// rtl/nibble_add_sequencer_if.sv - request/response bundle between a requester and the nibble add sequencer
interface nibble_add_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, result, cout
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - wide adder built by stepping a 4-bit delayed adder one nibble at a time
module nibble_add_sequencer #(
  parameter int NIBBLES       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nibble_add_sequencer_if.slave req,
  output logic [3:0]            adder_a,
  output logic [3:0]            adder_b,
  output logic                  adder_ci,
  input  logic [3:0]            adder_sum,
  input  logic                  adder_co
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  shadow;
  logic [W-1:0]  shadow_cap;
  logic [W-1:0]  result_q;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic          cout_q;

  assign idx_nxt    = idx + 3'd1;
  assign req.busy   = busy_q;
  assign req.done   = done_q;
  assign req.result = result_q;
  assign req.cout   = cout_q;

  // Shadow including the nibble being captured this edge, so the final
  // nibble lands in result on the same edge it is sampled.
  always_comb begin
    shadow_cap = shadow;
    shadow_cap[{idx, 2'b00} +: 4] = adder_sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow   <= '0;
      result_q <= '0;
      idx      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      adder_a  <= 4'd0;
      adder_b  <= 4'd0;
      adder_ci <= 1'b0;
    end else begin
      case (state)
        // FIN accepts start too, giving back-to-back operation
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (req.start) begin
            a_q      <= req.op_a;
            b_q      <= req.op_b;
            adder_a  <= req.op_a[3:0];
            adder_b  <= req.op_b[3:0];
            adder_ci <= req.cin;
            idx      <= 3'd0;
            cnt      <= CW'(SETTLE_CYCLES);
            busy_q   <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            shadow <= shadow_cap;
            if (idx == 3'(NIBBLES - 1)) begin
              result_q <= shadow_cap;
              cout_q   <= adder_co;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              adder_a  <= 4'd0;
              adder_b  <= 4'd0;
              adder_ci <= 1'b0;
              state    <= FIN;
            end else begin
              adder_a  <= a_q[{idx_nxt, 2'b00} +: 4];
              adder_b  <= b_q[{idx_nxt, 2'b00} +: 4];
              adder_ci <= adder_co;
              idx      <= idx_nxt;
              cnt      <= CW'(SETTLE_CYCLES);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - directed self-checking bench with a 12-unit delayed 4-bit adder model
`timescale 1ns/1ps
module tb_nibble_add_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] adder_a;
  logic [3:0] adder_b;
  logic       adder_ci;
  logic [3:0] adder_sum;
  logic       adder_co;

  int vectors = 0;
  int miscompares = 0;

  nibble_add_sequencer_if #(.NIBBLES(4)) bus ();

  nibble_add_sequencer #(.NIBBLES(4), .SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_ci  (adder_ci),
    .adder_sum (adder_sum),
    .adder_co  (adder_co)
  );

  always #5 clk = ~clk;

  assign #12 {adder_co, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_ci};

  // Drives start across one rising edge; returns at the negedge after acceptance.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = ci;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout waited %0d cycles, required done=1", cyc);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.op_a  = 16'($urandom);
    bus.op_b  = 16'($urandom);
    bus.cin   = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.result !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_hold busy/done/cout=%b result=%h, required 000/0000",
               {bus.busy, bus.done, bus.cout}, bus.result);
    end
    vectors++;
    if ({adder_a, adder_b, adder_ci} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_adder got a=%h b=%h ci=%b, required 0", adder_a, adder_b, adder_ci);
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.result !== 16'h0 || adder_a !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_release busy=%b result=%h adder_a=%h, required 0", bus.busy, bus.result, adder_a);
    end
  endtask

  task automatic test_basic_add();
    int cyc;
    logic [3:0] exp_a [4];
    exp_a[0] = 4'h4; exp_a[1] = 4'h3; exp_a[2] = 4'h2; exp_a[3] = 4'h1;
    start_op(16'h1234, 16'h4321, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy got %b, required 1", bus.busy);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (2) @(negedge clk);
      vectors++;
      if (adder_a !== exp_a[k]) begin
        miscompares++;
        $display("FAIL basic_adder_a nibble %0d got %h, required %h", k, adder_a, exp_a[k]);
      end
    end
    // Six edges have passed since acceptance; done follows the eighth.
    wait_done(cyc);
    cyc += 6;
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL basic_latency got %0d cycles, required 8", cyc);
    end
    vectors++;
    if (bus.result !== 16'h5555 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result got %h cout %b, required 5555 cout 0", bus.result, bus.cout);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h5555) begin
      miscompares++;
      $display("FAIL basic_after done=%b busy=%b result=%h, required 0 0 5555", bus.done, bus.busy, bus.result);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    vectors++;
    if (adder_ci !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_ci nibble 0 got %b, required 0", adder_ci);
    end
    for (int k = 1; k < 4; k++) begin
      repeat (2) @(negedge clk);
      vectors++;
      if (adder_ci !== 1'b1) begin
        miscompares++;
        $display("FAIL ripple_ci nibble %0d got %b, required 1", k, adder_ci);
      end
    end
    wait_done(cyc);
    vectors++;
    if (bus.result !== 16'h0000 || bus.cout !== 1'b1) begin
      miscompares++;
      $display("FAIL ripple_result got %h cout %b, required 0000 cout 1", bus.result, bus.cout);
    end
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_done(cyc);
    vectors++;
    if (bus.result !== 16'h0000 || bus.cout !== 1'b1 || cyc !== 8) begin
      miscompares++;
      $display("FAIL ripple_cin got %h cout %b lat %0d, required 0000 cout 1 lat 8", bus.result, bus.cout, cyc);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    start_op(16'h00A0, 16'h0003, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_ignore_busy got %b, required 1", bus.busy);
    end
    wait_done(cyc);
    cyc += 2;
    vectors++;
    if (bus.result !== 16'h00A3 || bus.cout !== 1'b0 || cyc !== 8) begin
      miscompares++;
      $display("FAIL busy_ignore_result got %h cout %b lat %0d, required 00A3 cout 0 lat 8", bus.result, bus.cout, cyc);
    end
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore_idle got busy %b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_done(cyc);
    vectors++;
    if (bus.result !== 16'h0002) begin
      miscompares++;
      $display("FAIL b2b_first got %h, required 0002", bus.result);
    end
    bus.start = 1'b1;
    bus.op_a  = 16'h0F0F;
    bus.op_b  = 16'h0101;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || adder_a !== 4'hF || bus.result !== 16'h0002) begin
      miscompares++;
      $display("FAIL b2b_accept done=%b busy=%b adder_a=%h result=%h, required 0 1 f 0002",
               bus.done, bus.busy, adder_a, bus.result);
    end
    wait_done(cyc);
    vectors++;
    if (bus.result !== 16'h1010 || bus.cout !== 1'b0 || cyc !== 8) begin
      miscompares++;
      $display("FAIL b2b_result got %h cout %b lat %0d, required 1010 cout 0 lat 8", bus.result, bus.cout, cyc);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic saw;
    start_op(16'h8888, 16'h8888, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.result !== 16'h0 || {adder_a, adder_b, adder_ci} !== 9'd0) begin
      miscompares++;
      $display("FAIL midreset_clear busy=%b result=%h a=%h b=%h ci=%b, required all 0",
               bus.busy, bus.result, adder_a, adder_b, adder_ci);
    end
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) reset_n = 1'b1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_done got done/busy activity, required none");
    end
    start_op(16'h8888, 16'h8888, 1'b0);
    wait_done(cyc);
    vectors++;
    if (bus.result !== 16'h1110 || bus.cout !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_rerun got %h cout %b, required 1110 cout 1", bus.result, bus.cout);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
